// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI bus arbiter.
//   arb_state_e             arbiter FSM states (IDLE, BUSY, GAP)
//   DEFAULT_TIMEOUT_CYCLES  default BUSY abort limit, used only when
//                           SPI_ARB_TIMEOUT_EN is defined
//   ptr_width()             bits needed to count 0..n-1 (always at least 1)
//   wrap_add()              (base + offset) mod n, for base < n and offset <= n
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  function automatic int ptr_width(input int n);
    int w;
    w = 1;
    for (int b = 1; b < 31; b++) begin
      if ((1 << b) < n) w = b + 1;
    end
    return w;
  endfunction

  function automatic int wrap_add(input int base, input int offset, input int n);
    int s;
    s = base + offset;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Scans the request vector starting one position above rr_ptr and wraps
// modulo NUM_REQ; the first set bit wins.
// Ports:
//   req            in   NUM_REQ  request vector
//   rr_ptr         in   PTR_W    index of the most recent winner
//   winner_onehot  out  NUM_REQ  one-hot winner (0 when no request)
//   winner_idx     out  PTR_W    binary winner index (0 when no request)
//   any_req        out  1        at least one request is pending
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner_onehot,
  output logic [PTR_W-1:0]   winner_idx,
  output logic               any_req
);

  // Outer loop walks the priority order (distance from rr_ptr); the inner
  // loop finds which requester sits at that distance. any_req doubles as
  // the "already found" flag so only the highest-priority hit is taken.
  always_comb begin
    winner_onehot = '0;
    winner_idx    = '0;
    any_req       = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_req && req[i] && (wrap_add(int'(rr_ptr), k, NUM_REQ) == i)) begin
          any_req          = 1'b1;
          winner_onehot[i] = 1'b1;
          winner_idx       = PTR_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one SPI master among NUM_REQ register-access
// requesters with round-robin grant, one transaction at a time, and fans the
// master's chip select out to the current owner's device.
// Optional feature macro: SPI_ARB_TIMEOUT_EN -- aborts a BUSY transaction
// after TIMEOUT_CYCLES clocks without spi_done (resp_err flags the abort).
// Without the macro BUSY waits for spi_done indefinitely and resp_err is 0.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_addr/req_wdata/req_read  requester side, slice i = requester i
//   grant       one-hot owner for the whole transaction
//   resp_done   1-clk pulse to the owner at transaction end
//   resp_rdata  read data, valid with resp_done, held until the next one
//   resp_err    high with resp_done on timeout abort
//   spi_addr/spi_wdata/spi_read/spi_enable  to the SPI master
//   spi_done/spi_rdata/spi_cs               from the SPI master
//   dev_cs      per-device chip select, spi_cs for the owner, 1 otherwise
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]   req_read,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   resp_done,
  output logic [7:0]           resp_rdata,
  output logic                 resp_err,
  output logic [7:0]           spi_addr,
  output logic [7:0]           spi_wdata,
  output logic                 spi_read,
  output logic                 spi_enable,
  input  logic                 spi_done,
  input  logic [7:0]           spi_rdata,
  input  logic                 spi_cs,
  output logic [NUM_REQ-1:0]   dev_cs
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam int GAP_W = ptr_width(GAP_CYCLES);
  localparam logic [PTR_W-1:0] RR_RESET = PTR_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [7:0]           spi_addr_q, spi_addr_d;
  logic [7:0]           spi_wdata_q, spi_wdata_d;
  logic                 spi_read_q, spi_read_d;
  logic                 spi_enable_q, spi_enable_d;
  logic [NUM_REQ-1:0]   resp_done_q, resp_done_d;
  logic [7:0]           resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;

  logic [NUM_REQ-1:0]   win_onehot;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_any;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = ptr_width(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req           (req_valid),
    .rr_ptr        (rr_ptr_q),
    .winner_onehot (win_onehot),
    .winner_idx    (win_idx),
    .any_req       (win_any)
  );

  // Next-state and output logic. The request fields of the winner are
  // captured at grant time so the SPI master sees a stable command even if
  // the requester misbehaves while BUSY.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    spi_addr_d   = spi_addr_q;
    spi_wdata_d  = spi_wdata_q;
    spi_read_d   = spi_read_q;
    spi_enable_d = spi_enable_q;
    resp_done_d  = '0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = 1'b0;
    gap_cnt_d    = gap_cnt_q;
`ifdef SPI_ARB_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (win_any) begin
          grant_d      = win_onehot;
          rr_ptr_d     = win_idx;
          spi_enable_d = 1'b1;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
              spi_addr_d  = req_addr[i*8 +: 8];
              spi_wdata_d = req_wdata[i*8 +: 8];
              spi_read_d  = req_read[i];
            end
          end
`ifdef SPI_ARB_TIMEOUT_EN
          to_cnt_d     = '0;
`endif
          state_d      = BUSY;
        end
      end

      // grant_q is the one-hot owner, so it directly selects the done pulse.
      BUSY: begin
        if (spi_done) begin
          resp_done_d  = grant_q;
          resp_rdata_d = spi_rdata;
          spi_enable_d = 1'b0;
          grant_d      = '0;
          gap_cnt_d    = '0;
          state_d      = GAP;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          resp_done_d  = grant_q;
          resp_rdata_d = 8'h00;
          resp_err_d   = 1'b1;
          spi_enable_d = 1'b0;
          grant_d      = '0;
          gap_cnt_d    = '0;
          state_d      = GAP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end

      // Requests are deliberately not looked at here; the owner uses this
      // window to drop req_valid before arbitration resumes.
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any transaction in flight without a response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= RR_RESET;
      spi_addr_q   <= 8'h00;
      spi_wdata_q  <= 8'h00;
      spi_read_q   <= 1'b0;
      spi_enable_q <= 1'b0;
      resp_done_q  <= '0;
      resp_rdata_q <= 8'h00;
      resp_err_q   <= 1'b0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      spi_addr_q   <= spi_addr_d;
      spi_wdata_q  <= spi_wdata_d;
      spi_read_q   <= spi_read_d;
      spi_enable_q <= spi_enable_d;
      resp_done_q  <= resp_done_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // BUSY clock counter for the abort path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  // Only the owner's device sees the master's chip select; everyone else
  // stays deselected, including while no one is granted.
  assign dev_cs     = ~grant_q | {NUM_REQ{spi_cs}};

  assign grant      = grant_q;
  assign resp_done  = resp_done_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign spi_addr   = spi_addr_q;
  assign spi_wdata  = spi_wdata_q;
  assign spi_read   = spi_read_q;
  assign spi_enable = spi_enable_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Testbench for spi_bus_arbiter (NUM_REQ=2, GAP_CYCLES=4, TIMEOUT_CYCLES=16).
// Directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_spi_bus_arbiter;

  localparam int N   = 2;
  localparam int GAP = 4;
  localparam int TO  = 16;
  localparam int AW  = 8 * N;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_wdata;
  logic [N-1:0]  req_read;
  logic [N-1:0]  grant;
  logic [N-1:0]  resp_done;
  logic [7:0]    resp_rdata;
  logic          resp_err;
  logic [7:0]    spi_addr;
  logic [7:0]    spi_wdata;
  logic          spi_read;
  logic          spi_enable;
  logic          spi_done;
  logic [7:0]    spi_rdata;
  logic          spi_cs;
  logic [N-1:0]  dev_cs;

  spi_bus_arbiter #(
    .NUM_REQ        (N),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_read   (req_read),
    .grant      (grant),
    .resp_done  (resp_done),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .spi_addr   (spi_addr),
    .spi_wdata  (spi_wdata),
    .spi_read   (spi_read),
    .spi_enable (spi_enable),
    .spi_done   (spi_done),
    .spi_rdata  (spi_rdata),
    .spi_cs     (spi_cs),
    .dev_cs     (dev_cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: who owns the bus (-1 = nobody), clocks of cooldown left,
  // last winner, clocks spent in the current transaction.
  int           m_owner;
  int           m_cool;
  int           m_rr;
  int           m_busy;
  int           spi_wait;
  logic [N-1:0] e_grant;
  logic [N-1:0] e_done;
  logic [7:0]   e_rdata;
  logic         e_err;
  logic [7:0]   e_addr;
  logic [7:0]   e_wdata;
  logic         e_read;
  logic         e_enable;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_cool   = 0;
    m_rr     = N - 1;
    m_busy   = 0;
    e_grant  = '0;
    e_done   = '0;
    e_rdata  = 8'h00;
    e_err    = 1'b0;
    e_addr   = 8'h00;
    e_wdata  = 8'h00;
    e_read   = 1'b0;
    e_enable = 1'b0;
  endtask

  task automatic model_finish(input logic [7:0] data, input logic err);
    e_done   = N'(1) << m_owner;
    e_rdata  = data;
    e_err    = err;
    e_enable = 1'b0;
    e_grant  = '0;
    m_owner  = -1;
    m_cool   = GAP;
  endtask

  // Advance the model across the coming clock edge using the current inputs.
  task automatic modelStep();
    bit found;
    int j;
    if (reset == 1'b0) begin
      model_reset();
    end else begin
      e_done = '0;
      e_err  = 1'b0;
      if (m_owner >= 0) begin
        m_busy++;
        if (spi_done) model_finish(spi_rdata, 1'b0);
        else if (TO_EN && m_busy == TO) model_finish(8'h00, 1'b1);
      end else if (m_cool > 0) begin
        m_cool--;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          j = (m_rr + k) % N;
          if (!found && ((req_valid >> j) & N'(1)) != '0) begin
            found    = 1'b1;
            m_owner  = j;
            m_rr     = j;
            m_busy   = 0;
            e_grant  = N'(1) << j;
            e_addr   = 8'(req_addr >> (8 * j));
            e_wdata  = 8'(req_wdata >> (8 * j));
            e_read   = ((req_read >> j) & N'(1)) != '0;
            e_enable = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic [N-1:0] exp_dev;
    if (spi_cs) exp_dev = '1;
    else        exp_dev = ~e_grant;
    chk("grant", int'(grant), int'(e_grant));
    chk("resp_done", int'(resp_done), int'(e_done));
    chk("resp_rdata", int'(resp_rdata), int'(e_rdata));
    chk("resp_err", int'(resp_err), int'(e_err));
    chk("spi_enable", int'(spi_enable), int'(e_enable));
    chk("dev_cs", int'(dev_cs), int'(exp_dev));
    if (e_enable) begin
      chk("spi_addr", int'(spi_addr), int'(e_addr));
      chk("spi_wdata", int'(spi_wdata), int'(e_wdata));
      chk("spi_read", int'(spi_read), int'(e_read));
    end
  endtask

  // Inputs are set at the falling edge; this advances one clock and checks.
  task automatic step_cycle();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] w, input logic r);
    logic [AW-1:0] mask;
    mask      = AW'(8'hFF) << (8 * i);
    req_addr  = (req_addr & ~mask) | (AW'(a) << (8 * i));
    req_wdata = (req_wdata & ~mask) | (AW'(w) << (8 * i));
    req_read  = (req_read & ~(N'(1) << i)) | (N'(r) << i);
    req_valid = req_valid | (N'(1) << i);
  endtask

  task automatic clr_req(input int i);
    req_valid = req_valid & ~(N'(1) << i);
  endtask

  task automatic do_reset();
    req_valid = '0;
    spi_done  = 1'b0;
    reset     = 1'b0;
    step_cycle();
    step_cycle();
    reset     = 1'b1;
    step_cycle();
  endtask

  // Random requesters and a random-latency SPI master, driven from model state.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      if (((e_done >> i) & N'(1)) != '0) begin
        clr_req(i);
      end else if (((req_valid >> i) & N'(1)) == '0 && $urandom_range(0, 2) == 0) begin
        set_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
      end
    end
    spi_done  = 1'b0;
    spi_rdata = 8'($urandom);
    spi_cs    = 1'($urandom);
    if (e_enable) begin
      if (spi_wait < 0) spi_wait = $urandom_range(0, 10);
      if (spi_wait == 0) begin
        spi_done = 1'b1;
        spi_wait = -1;
      end else begin
        spi_wait--;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      spi_done = 1'b1;
    end
  endtask

  int n;
  int idx;
  int rot_exp [6];

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_read  = '0;
    spi_done  = 1'b0;
    spi_rdata = 8'h00;
    spi_cs    = 1'b0;
    spi_wait  = -1;
    model_reset();

    // Reset values
    repeat (3) step_cycle();
    chk("rst_grant", int'(grant), 0);
    chk("rst_spi_enable", int'(spi_enable), 0);
    chk("rst_resp_rdata", int'(resp_rdata), 0);
    chk("rst_dev_cs", int'(dev_cs), 3);
    chk("rst_spi_addr", int'(spi_addr), 0);
    reset = 1'b1;
    step_cycle();

    // Single read
    $display("[TB] single read");
    set_req(0, 8'h22, 8'h00, 1'b1);
    step_cycle();
    chk("rd_spi_enable", int'(spi_enable), 1);
    chk("rd_grant", int'(grant), 1);
    chk("rd_spi_addr", int'(spi_addr), 8'h22);
    chk("rd_dev_cs_low", int'(dev_cs), 2);
    spi_cs = 1'b1;
    #1;
    chk("rd_dev_cs_high", int'(dev_cs), 3);
    spi_cs = 1'b0;
    repeat (19) step_cycle();
    spi_done  = 1'b1;
    spi_rdata = 8'h5A;
    step_cycle();
    chk("rd_resp_done", int'(resp_done), 1);
    chk("rd_resp_rdata", int'(resp_rdata), 8'h5A);
    chk("rd_grant_off", int'(grant), 0);
    clr_req(0);
    spi_done = 1'b0;
    step_cycle();
    chk("rd_done_pulse", int'(resp_done), 0);
    chk("rd_rdata_held", int'(resp_rdata), 8'h5A);
    repeat (GAP) step_cycle();

    // Contention after reset: 0 then 1, spaced GAP+1 clocks
    $display("[TB] contention");
    do_reset();
    set_req(0, 8'h10, 8'h11, 1'b0);
    set_req(1, 8'h20, 8'h21, 1'b1);
    step_cycle();
    chk("cont_grant0", int'(grant), 1);
    repeat (2) step_cycle();
    spi_done  = 1'b1;
    spi_rdata = 8'h33;
    step_cycle();
    chk("cont_done0", int'(resp_done), 1);
    clr_req(0);
    spi_done = 1'b0;
    n = 0;
    while (grant == '0 && n < 20) begin
      step_cycle();
      n++;
    end
    chk("cont_gap_to_grant1", n, GAP + 1);
    chk("cont_grant1", int'(grant), 2);
    spi_done = 1'b1;
    step_cycle();
    clr_req(1);
    spi_done = 1'b0;
    repeat (GAP) step_cycle();

    // Rotation with both requesters always active
    $display("[TB] rotation");
    rot_exp = '{0, 1, 0, 1, 0, 1};
    do_reset();
    set_req(0, 8'h01, 8'h02, 1'b1);
    set_req(1, 8'h03, 8'h04, 1'b0);
    for (int t = 0; t < 6; t++) begin
      n = 0;
      while (grant == '0 && n < 30) begin
        step_cycle();
        n++;
      end
      idx = (grant == 2'b10) ? 1 : 0;
      chk($sformatf("rot_grant%0d", t), idx, rot_exp[t]);
      step_cycle();
      spi_done = 1'b1;
      step_cycle();
      spi_done = 1'b0;
      clr_req(idx);
      step_cycle();
      set_req(idx, 8'(t), 8'(t + 8), 1'b1);
    end
    req_valid = '0;
    repeat (GAP + 2) step_cycle();

    // Reset in the middle of a transaction
    $display("[TB] reset mid-busy");
    do_reset();
    set_req(0, 8'h44, 8'h55, 1'b0);
    step_cycle();
    repeat (5) step_cycle();
    reset = 1'b0;
    #1;
    chk("rmb_spi_enable", int'(spi_enable), 0);
    chk("rmb_grant", int'(grant), 0);
    chk("rmb_dev_cs", int'(dev_cs), 3);
    model_reset();
    spi_done = 1'b1;
    step_cycle();
    chk("rmb_no_done", int'(resp_done), 0);
    spi_done = 1'b0;
    clr_req(0);
    reset = 1'b1;
    step_cycle();
    step_cycle();
    chk("rmb_no_done_after", int'(resp_done), 0);

    // Stuck transaction: a nonzero read first so a cleared rdata is visible
    $display("[TB] stuck transaction");
    set_req(1, 8'h66, 8'h77, 1'b1);
    step_cycle();
    spi_done  = 1'b1;
    spi_rdata = 8'hC3;
    step_cycle();
    clr_req(1);
    spi_done = 1'b0;
    repeat (GAP) step_cycle();
    set_req(0, 8'h88, 8'h99, 1'b1);
    step_cycle();
`ifdef SPI_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      step_cycle();
      if (k < TO) begin
        chk($sformatf("to_wait%0d", k), int'(resp_done), 0);
      end
    end
    chk("to_resp_done", int'(resp_done), 1);
    chk("to_resp_err", int'(resp_err), 1);
    chk("to_resp_rdata", int'(resp_rdata), 0);
    clr_req(0);
    repeat (GAP) step_cycle();
`else
    repeat (100) step_cycle();
    chk("stuck_grant", int'(grant), 1);
    chk("stuck_spi_enable", int'(spi_enable), 1);
    chk("stuck_resp_done", int'(resp_done), 0);
    chk("stuck_rdata_held", int'(resp_rdata), 8'hC3);
    do_reset();
`endif

    // Randomized traffic against the model
    $display("[TB] random traffic");
    do_reset();
    spi_wait = -1;
    repeat (3000) begin
      applyStimulus();
      step_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
